// File: rtl/prog_loader_pkg.sv
// Shared definitions for the host-side programming front end.
// Contents: loader FSM state encoding, strobe generator phase encoding,
// command byte values, status error codes and the HOST_READY decode helper.
`timescale 1ns/1ps
package prog_loader_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_CMD      = 4'd1,
    ST_LENH     = 4'd2,
    ST_LENL     = 4'd3,
    ST_EXEC     = 4'd4,
    ST_PAY_WAIT = 4'd5,
    ST_PAY_HI   = 4'd6,
    ST_PAY_LO   = 4'd7,
    ST_CHK      = 4'd8,
    ST_ACK_WAIT = 4'd9,
    ST_SCK_HI   = 4'd10,
    ST_SCK_LO   = 4'd11,
    ST_FAIL     = 4'd12
  } state_e;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_HI   = 2'd1,
    PH_LO   = 2'd2
  } phase_e;

  localparam logic [7:0] CMD_START   = 8'h10;
  localparam logic [7:0] CMD_SECTION = 8'h20;
  localparam logic [7:0] CMD_END     = 8'h30;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CHKSUM  = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_SEQ     = 2'd3;

  // States in which the loader can take a byte from the host.
  function automatic logic host_ready_for(input state_e st);
    logic rdy;
    case (st)
      ST_IDLE, ST_CMD, ST_LENH, ST_LENL, ST_PAY_WAIT, ST_CHK: rdy = 1'b1;
      default:                                                rdy = 1'b0;
    endcase
    return rdy;
  endfunction

endpackage

// File: rtl/prog_strobe_gen.sv
// Single strobe generator shared by PCK and SCK.
// A start request while idle produces StrobeCycles high cycles on the
// selected strobe, then StrobeCycles low cycles, then a one-cycle done.
// Ports: clk, rst_n (async active-low), start, sel_sck (1: SCK, 0: PCK),
//        pck, sck (registered strobes), idle, low_phase, done.
`timescale 1ns/1ps
module prog_strobe_gen
  import prog_loader_pkg::*;
#(
  parameter int StrobeCycles = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic sel_sck,
  output logic pck,
  output logic sck,
  output logic idle,
  output logic low_phase,
  output logic done
);
  localparam int             CW   = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;
  localparam logic [CW-1:0]  LAST = CW'(StrobeCycles - 1);

  phase_e        phase_r;
  logic [CW-1:0] cnt_r;
  logic          pck_r;
  logic          sck_r;
  logic          done_r;

  // Phase sequencer: high phase, low phase, then a done pulse back to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r <= PH_IDLE;
      cnt_r   <= '0;
      pck_r   <= 1'b0;
      sck_r   <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (phase_r)
        PH_IDLE: begin
          if (start) begin
            phase_r <= PH_HI;
            cnt_r   <= '0;
            pck_r   <= ~sel_sck;
            sck_r   <= sel_sck;
          end
        end
        PH_HI: begin
          if (cnt_r == LAST) begin
            phase_r <= PH_LO;
            cnt_r   <= '0;
            pck_r   <= 1'b0;
            sck_r   <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        PH_LO: begin
          if (cnt_r == LAST) begin
            phase_r <= PH_IDLE;
            cnt_r   <= '0;
            done_r  <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          phase_r <= PH_IDLE;
          cnt_r   <= '0;
          pck_r   <= 1'b0;
          sck_r   <= 1'b0;
        end
      endcase
    end
  end

  assign pck       = pck_r;
  assign sck       = sck_r;
  assign done      = done_r;
  assign idle      = (phase_r == PH_IDLE);
  assign low_phase = (phase_r == PH_LO);

endmodule

// File: rtl/prog_loader.sv
// Host-side programming front end for the CPU programmer port.
// Parses frames {SyncByte, CMD, LEN_H, LEN_L, payload[LEN], CHK} from a
// valid/ready byte stream, holds the CPU in programming mode, streams
// payload bytes with PCK strobes, advances sections with SCK and reports
// busy/done/error status.
// Ports: CLK, nRST (async active-low); HOST_DATA/HOST_VALID/HOST_READY host
//        link; PROGRAMMER_* CPU programmer port; STATUS_* session status.
`timescale 1ns/1ps
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int         StrobeCycles = 4,
  parameter int         AckTimeout   = 65535,
  parameter logic [7:0] SyncByte     = 8'hA5
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic [7:0] HOST_DATA,
  input  logic       HOST_VALID,
  output logic       HOST_READY,
  output logic       PROGRAMMER_Reset,
  output logic [7:0] PROGRAMMER_InputData,
  output logic       PROGRAMMER_PCK,
  output logic       PROGRAMMER_SCK,
  input  logic       PROGRAMMER_ACK,
  output logic       STATUS_BUSY,
  output logic       STATUS_DONE,
  output logic       STATUS_ERR,
  output logic [1:0] STATUS_CODE
);
  localparam logic [15:0] ACK_LAST = 16'(AckTimeout - 1);

  state_e      state_r, state_s;
  logic        host_ready_r;
  logic [7:0]  cmd_r, len_hi_r, len_lo_r, chk_r, data_r;
  logic [15:0] rem_r, ack_cnt_r;
  logic        ack_seen_r, prog_reset_r, busy_r, done_r, err_r;
  logic [1:0]  code_r, fail_code_s;
  logic        accept_s, chk_ok_s, len_zero_s;
  logic        strobe_start_s, strobe_sck_s;
  logic        gen_idle_s, gen_low_s, gen_done_s;

  assign accept_s   = HOST_VALID & host_ready_r;
  assign chk_ok_s   = (HOST_DATA == chk_r);
  assign len_zero_s = ({len_hi_r, len_lo_r} == 16'h0000);

  prog_strobe_gen #(.StrobeCycles(StrobeCycles)) u_strobe (
    .clk       (CLK),
    .rst_n     (nRST),
    .start     (strobe_start_s),
    .sel_sck   (strobe_sck_s),
    .pck       (PROGRAMMER_PCK),
    .sck       (PROGRAMMER_SCK),
    .idle      (gen_idle_s),
    .low_phase (gen_low_s),
    .done      (gen_done_s)
  );

  // State register; HOST_READY is registered from the next state so it always matches the state.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r      <= ST_IDLE;
      host_ready_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      host_ready_r <= host_ready_for(state_s);
    end
  end

  // Next-state decode, strobe requests and the error code carried into FAIL.
  always_comb begin
    state_s        = state_r;
    fail_code_s    = ERR_NONE;
    strobe_start_s = 1'b0;
    strobe_sck_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && (HOST_DATA == SyncByte)) state_s = ST_CMD;
        else                                     state_s = ST_IDLE;
      end
      ST_CMD: begin
        if (accept_s) state_s = ST_LENH;
        else          state_s = ST_CMD;
      end
      ST_LENH: begin
        if (accept_s) state_s = ST_LENL;
        else          state_s = ST_LENH;
      end
      ST_LENL: begin
        if (accept_s) state_s = ST_EXEC;
        else          state_s = ST_LENL;
      end
      ST_EXEC: begin
        case (cmd_r)
          CMD_START: begin
            if (len_zero_s) state_s = ST_ACK_WAIT;
            else begin state_s = ST_FAIL; fail_code_s = ERR_SEQ; end
          end
          CMD_SECTION: begin
            if (busy_r && ack_seen_r) state_s = ST_SCK_HI;
            else begin state_s = ST_FAIL; fail_code_s = ERR_SEQ; end
          end
          CMD_END: begin
            if (busy_r && len_zero_s) state_s = ST_CHK;
            else begin state_s = ST_FAIL; fail_code_s = ERR_SEQ; end
          end
          default: begin
            state_s     = ST_FAIL;
            fail_code_s = ERR_SEQ;
          end
        endcase
      end
      ST_ACK_WAIT: begin
        if (PROGRAMMER_ACK)              state_s = ST_CHK;
        else if (ack_cnt_r >= ACK_LAST) begin state_s = ST_FAIL; fail_code_s = ERR_TIMEOUT; end
        else                             state_s = ST_ACK_WAIT;
      end
      ST_SCK_HI: begin
        strobe_start_s = gen_idle_s;
        strobe_sck_s   = 1'b1;
        if (gen_low_s) state_s = ST_SCK_LO;
        else           state_s = ST_SCK_HI;
      end
      ST_SCK_LO: begin
        if (gen_done_s) state_s = len_zero_s ? ST_CHK : ST_PAY_WAIT;
        else            state_s = ST_SCK_LO;
      end
      ST_PAY_WAIT: begin
        if (accept_s) state_s = ST_PAY_HI;
        else          state_s = ST_PAY_WAIT;
      end
      ST_PAY_HI: begin
        // Strobe starts one cycle after the byte is latched, giving data setup before PCK rises.
        strobe_start_s = gen_idle_s;
        if (gen_low_s) state_s = ST_PAY_LO;
        else           state_s = ST_PAY_HI;
      end
      ST_PAY_LO: begin
        if (gen_done_s) state_s = (rem_r == 16'd1) ? ST_CHK : ST_PAY_WAIT;
        else            state_s = ST_PAY_LO;
      end
      ST_CHK: begin
        if (accept_s && !chk_ok_s) begin state_s = ST_FAIL; fail_code_s = ERR_CHKSUM; end
        else if (accept_s)         state_s = ST_IDLE;
        else                       state_s = ST_CHK;
      end
      ST_FAIL: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Frame capture, running checksum, counters and session status.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cmd_r        <= 8'h00;
      len_hi_r     <= 8'h00;
      len_lo_r     <= 8'h00;
      chk_r        <= 8'h00;
      data_r       <= 8'h00;
      rem_r        <= 16'h0000;
      ack_cnt_r    <= 16'h0000;
      ack_seen_r   <= 1'b0;
      prog_reset_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      code_r       <= ERR_NONE;
    end else begin
      case (state_r)
        ST_IDLE: if (accept_s && (HOST_DATA == SyncByte)) chk_r <= 8'h00;
        ST_CMD: begin
          if (accept_s) begin
            cmd_r <= HOST_DATA;
            chk_r <= chk_r ^ HOST_DATA;
          end
        end
        ST_LENH: begin
          if (accept_s) begin
            len_hi_r <= HOST_DATA;
            chk_r    <= chk_r ^ HOST_DATA;
          end
        end
        ST_LENL: begin
          if (accept_s) begin
            len_lo_r <= HOST_DATA;
            chk_r    <= chk_r ^ HOST_DATA;
          end
        end
        ST_EXEC: begin
          if (state_s == ST_ACK_WAIT) begin
            prog_reset_r <= 1'b1;
            busy_r       <= 1'b1;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            code_r       <= ERR_NONE;
            ack_seen_r   <= 1'b0;
            ack_cnt_r    <= 16'h0000;
          end else if (state_s == ST_SCK_HI) begin
            rem_r <= {len_hi_r, len_lo_r};
          end
        end
        ST_ACK_WAIT: begin
          if (PROGRAMMER_ACK)               ack_seen_r <= 1'b1;
          else if (ack_cnt_r != 16'hFFFF)   ack_cnt_r  <= ack_cnt_r + 16'd1;
        end
        ST_PAY_WAIT: begin
          if (accept_s) begin
            data_r <= HOST_DATA;
            chk_r  <= chk_r ^ HOST_DATA;
          end
        end
        ST_PAY_LO: if (gen_done_s) rem_r <= rem_r - 16'd1;
        ST_CHK: begin
          if (accept_s && chk_ok_s && (cmd_r == CMD_END)) begin
            prog_reset_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b1;
          end
        end
        default: ;
      endcase
      // Failure keeps the CPU halted; only START or nRST clears the error.
      if (state_s == ST_FAIL) begin
        err_r  <= 1'b1;
        code_r <= fail_code_s;
        busy_r <= 1'b0;
        done_r <= 1'b0;
      end
    end
  end

  assign HOST_READY           = host_ready_r;
  assign PROGRAMMER_Reset     = prog_reset_r;
  assign PROGRAMMER_InputData = data_r;
  assign STATUS_BUSY          = busy_r;
  assign STATUS_DONE          = done_r;
  assign STATUS_ERR           = err_r;
  assign STATUS_CODE          = code_r;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader (StrobeCycles=4, AckTimeout=100).
`timescale 1ns/1ps
module tb_prog_loader;
  logic       clk = 1'b0;
  logic       nRST;
  logic [7:0] HOST_DATA;
  logic       HOST_VALID;
  logic       HOST_READY;
  logic       PROGRAMMER_Reset;
  logic [7:0] PROGRAMMER_InputData;
  logic       PROGRAMMER_PCK;
  logic       PROGRAMMER_SCK;
  logic       PROGRAMMER_ACK;
  logic       STATUS_BUSY;
  logic       STATUS_DONE;
  logic       STATUS_ERR;
  logic [1:0] STATUS_CODE;

  int total = 0;
  int bad   = 0;

  // Strobe monitor state (written only by the monitor process).
  int         pck_rises = 0, sck_rises = 0, pck_hi = 0, sck_hi = 0;
  int         unstable = 0, rdy_viol = 0, overlap = 0, gap_viol = 0;
  int         low_run = 100;
  logic       pck_q = 1'b0, sck_q = 1'b0;
  logic [7:0] data_q = 8'h00;
  logic [7:0] pck_data [8];

  prog_loader #(.StrobeCycles(4), .AckTimeout(100), .SyncByte(8'hA5)) dut (
    .CLK                  (clk),
    .nRST                 (nRST),
    .HOST_DATA            (HOST_DATA),
    .HOST_VALID           (HOST_VALID),
    .HOST_READY           (HOST_READY),
    .PROGRAMMER_Reset     (PROGRAMMER_Reset),
    .PROGRAMMER_InputData (PROGRAMMER_InputData),
    .PROGRAMMER_PCK       (PROGRAMMER_PCK),
    .PROGRAMMER_SCK       (PROGRAMMER_SCK),
    .PROGRAMMER_ACK       (PROGRAMMER_ACK),
    .STATUS_BUSY          (STATUS_BUSY),
    .STATUS_DONE          (STATUS_DONE),
    .STATUS_ERR           (STATUS_ERR),
    .STATUS_CODE          (STATUS_CODE)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    pck_q  <= PROGRAMMER_PCK;
    sck_q  <= PROGRAMMER_SCK;
    data_q <= PROGRAMMER_InputData;
    if (PROGRAMMER_PCK && !pck_q) begin
      pck_data[pck_rises % 8] <= PROGRAMMER_InputData;
      pck_rises <= pck_rises + 1;
    end
    if (PROGRAMMER_SCK && !sck_q) sck_rises <= sck_rises + 1;
    if (PROGRAMMER_PCK) pck_hi <= pck_hi + 1;
    if (PROGRAMMER_SCK) sck_hi <= sck_hi + 1;
    if (PROGRAMMER_PCK && (PROGRAMMER_InputData !== data_q)) unstable <= unstable + 1;
    if ((PROGRAMMER_PCK || PROGRAMMER_SCK) && HOST_READY) rdy_viol <= rdy_viol + 1;
    if (PROGRAMMER_PCK && PROGRAMMER_SCK) overlap <= overlap + 1;
    if (PROGRAMMER_PCK || PROGRAMMER_SCK) begin
      if (((PROGRAMMER_PCK && !pck_q) || (PROGRAMMER_SCK && !sck_q)) && (low_run < 4))
        gap_viol <= gap_viol + 1;
      low_run <= 0;
    end else begin
      low_run <= low_run + 1;
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    HOST_DATA  = b;
    HOST_VALID = 1'b1;
    while (!HOST_READY && (n < 2000)) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    assert (n < 2000) else begin
      bad++;
      $error("FAIL ready_timeout: observed=%0d cycles expected=<2000 for byte %0h", n, b);
    end
    @(posedge clk);
    #1;
    HOST_VALID = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] lh, input logic [7:0] ll, input logic [7:0] chk);
    send_byte(8'hA5);
    send_byte(cmd);
    send_byte(lh);
    send_byte(ll);
    send_byte(chk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 16'(HOST_READY), 16'd0);
    check({tag, "_reset"}, 16'(PROGRAMMER_Reset), 16'd0);
    check({tag, "_data"},  16'(PROGRAMMER_InputData), 16'h00);
    check({tag, "_pck"},   16'(PROGRAMMER_PCK), 16'd0);
    check({tag, "_sck"},   16'(PROGRAMMER_SCK), 16'd0);
    check({tag, "_busy"},  16'(STATUS_BUSY), 16'd0);
    check({tag, "_done"},  16'(STATUS_DONE), 16'd0);
    check({tag, "_err"},   16'(STATUS_ERR), 16'd0);
    check({tag, "_code"},  16'(STATUS_CODE), 16'd0);
  endtask

  initial begin
    int p0, s0, ph0, sh0;
    nRST           = 1'b0;
    HOST_DATA      = 8'h00;
    HOST_VALID     = 1'b0;
    PROGRAMMER_ACK = 1'b0;

    // Reset state
    #3;
    check_all_zero("rst");
    tick(2);
    nRST = 1'b1;
    tick(1);
    check("idle_ready", 16'(HOST_READY), 16'd1);

    // SECTION before START -> sequence error, no strobes
    send_frame(8'h20, 8'h00, 8'h00, 8'h20);
    tick(2);
    check("sec_early_err",  16'(STATUS_ERR), 16'd1);
    check("sec_early_code", 16'(STATUS_CODE), 16'd3);
    check("sec_early_rst",  16'(PROGRAMMER_Reset), 16'd0);
    check("sec_early_pck",  16'(pck_rises), 16'd0);
    check("sec_early_sck",  16'(sck_rises), 16'd0);

    // START, ACK after 20 cycles
    send_byte(8'hA5);
    send_byte(8'h10);
    send_byte(8'h00);
    send_byte(8'h00);
    tick(1);
    check("start_reset", 16'(PROGRAMMER_Reset), 16'd1);
    check("start_busy",  16'(STATUS_BUSY), 16'd1);
    check("start_err",   16'(STATUS_ERR), 16'd0);
    check("start_code",  16'(STATUS_CODE), 16'd0);
    tick(19);
    check("ackwait_ready", 16'(HOST_READY), 16'd0);
    PROGRAMMER_ACK = 1'b1;
    send_byte(8'h10);
    tick(1);
    check("start_idle_ready", 16'(HOST_READY), 16'd1);
    check("start_busy2",      16'(STATUS_BUSY), 16'd1);
    check("start_err2",       16'(STATUS_ERR), 16'd0);

    // SECTION LEN=3, payload 11 22 33, CHK 23
    p0 = pck_rises; s0 = sck_rises; ph0 = pck_hi; sh0 = sck_hi;
    send_byte(8'hA5);
    send_byte(8'h20);
    send_byte(8'h00);
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h23);
    tick(2);
    check("sec_sck_pulses", 16'(sck_rises - s0), 16'd1);
    check("sec_sck_width",  16'(sck_hi - sh0), 16'd4);
    check("sec_pck_pulses", 16'(pck_rises - p0), 16'd3);
    check("sec_pck_width",  16'(pck_hi - ph0), 16'd12);
    check("sec_data0", 16'(pck_data[(p0 + 0) % 8]), 16'h11);
    check("sec_data1", 16'(pck_data[(p0 + 1) % 8]), 16'h22);
    check("sec_data2", 16'(pck_data[(p0 + 2) % 8]), 16'h33);
    check("sec_err",   16'(STATUS_ERR), 16'd0);
    check("sec_busy",  16'(STATUS_BUSY), 16'd1);

    // Unknown command while busy -> sequence error, CPU stays halted
    send_frame(8'h55, 8'h00, 8'h00, 8'h55);
    tick(2);
    check("badcmd_err",  16'(STATUS_ERR), 16'd1);
    check("badcmd_code", 16'(STATUS_CODE), 16'd3);
    check("badcmd_rst",  16'(PROGRAMMER_Reset), 16'd1);
    check("badcmd_busy", 16'(STATUS_BUSY), 16'd0);

    // START clears the error (ACK already high)
    send_frame(8'h10, 8'h00, 8'h00, 8'h10);
    tick(2);
    check("restart_err",  16'(STATUS_ERR), 16'd0);
    check("restart_code", 16'(STATUS_CODE), 16'd0);
    check("restart_busy", 16'(STATUS_BUSY), 16'd1);

    // SECTION LEN=2 with wrong CHK (correct is 33): payload still streamed
    p0 = pck_rises;
    send_byte(8'hA5);
    send_byte(8'h20);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h44);
    send_byte(8'h55);
    send_byte(8'h00);
    tick(2);
    check("badchk_pck",  16'(pck_rises - p0), 16'd2);
    check("badchk_err",  16'(STATUS_ERR), 16'd1);
    check("badchk_code", 16'(STATUS_CODE), 16'd1);
    check("badchk_rst",  16'(PROGRAMMER_Reset), 16'd1);
    check("badchk_busy", 16'(STATUS_BUSY), 16'd0);

    // START clears, then END finishes the session
    send_frame(8'h10, 8'h00, 8'h00, 8'h10);
    tick(2);
    check("clr_err", 16'(STATUS_ERR), 16'd0);
    send_frame(8'h30, 8'h00, 8'h00, 8'h30);
    tick(2);
    check("end_reset", 16'(PROGRAMMER_Reset), 16'd0);
    check("end_done",  16'(STATUS_DONE), 16'd1);
    check("end_busy",  16'(STATUS_BUSY), 16'd0);
    check("end_err",   16'(STATUS_ERR), 16'd0);

    // START with ACK held low -> timeout after 100 cycles
    PROGRAMMER_ACK = 1'b0;
    send_byte(8'hA5);
    send_byte(8'h10);
    send_byte(8'h00);
    send_byte(8'h00);
    tick(90);
    check("to_early_err",  16'(STATUS_ERR), 16'd0);
    check("to_early_done", 16'(STATUS_DONE), 16'd0);
    check("to_early_busy", 16'(STATUS_BUSY), 16'd1);
    tick(20);
    check("to_err",   16'(STATUS_ERR), 16'd1);
    check("to_code",  16'(STATUS_CODE), 16'd2);
    check("to_reset", 16'(PROGRAMMER_Reset), 16'd1);
    check("to_busy",  16'(STATUS_BUSY), 16'd0);

    // nRST in the middle of a payload strobe
    PROGRAMMER_ACK = 1'b1;
    send_frame(8'h10, 8'h00, 8'h00, 8'h10);
    send_byte(8'hA5);
    send_byte(8'h20);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h66);
    tick(2);
    check("mid_pck",  16'(PROGRAMMER_PCK), 16'd1);
    check("mid_data", 16'(PROGRAMMER_InputData), 16'h66);
    #2;
    nRST = 1'b0;
    #1;
    check_all_zero("midrst");
    tick(2);
    nRST = 1'b1;
    tick(1);
    check("post_rst_ready", 16'(HOST_READY), 16'd1);

    // Strobe-wide invariants over the whole run
    check("data_stable",  16'(unstable), 16'd0);
    check("ready_low",    16'(rdy_viol), 16'd0);
    check("no_overlap",   16'(overlap), 16'd0);
    check("strobe_gap",   16'(gap_viol), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Host-side programming front end; sits directly upstream of the CPU unit's programmer port.
- Accepts a framed byte stream from a host link (valid/ready).
- Drives PROGRAMMER_Reset, PROGRAMMER_InputData, PROGRAMMER_PCK and PROGRAMMER_SCK, and waits on PROGRAMMER_ACK.
- Reports session status (busy/done/error) back to the host side.

Parameters:
StrobeCycles, 4, PCK/SCK high time and minimum low time, in CLK cycles (>=1)
AckTimeout, 65535, max cycles to wait for PROGRAMMER_ACK after asserting reset
SyncByte, 8'hA5, frame start marker

Ports:
CLK  in  1  system clock
nRST  in  1  asynchronous active-low reset
HOST_DATA  in  8  host byte
HOST_VALID  in  1  host byte valid
HOST_READY  out  1  byte accepted when VALID&READY on a rising CLK edge
PROGRAMMER_Reset  out  1  holds CPU in programming mode
PROGRAMMER_InputData  out  8  payload byte to the CPU programmer port
PROGRAMMER_PCK  out  1  byte strobe
PROGRAMMER_SCK  out  1  section (core image) advance strobe
PROGRAMMER_ACK  in  1  CPU ready for programming
STATUS_BUSY  out  1  session in progress
STATUS_DONE  out  1  sticky: last session ended cleanly
STATUS_ERR  out  1  sticky error flag
STATUS_CODE  out  2  error code: 0 none, 1 bad checksum, 2 ACK timeout, 3 bad command/sequence

Behaviour:
- Reset: all outputs 0 (InputData 8'h00, HOST_READY 0); FSM enters IDLE. Reset mid-session releases PROGRAMMER_Reset immediately and abandons the frame.
- Frame format: SyncByte, CMD, LEN_H, LEN_L, LEN payload bytes, CHK.
- CHK = XOR of CMD, LEN_H, LEN_L and all payload bytes. The running XOR restarts at each SyncByte.
- CMD values:
  - 8'h10 START: LEN must be 0.
  - 8'h20 SECTION: LEN 0..65535.
  - 8'h30 END: LEN must be 0.
  - Any other value: code 3.
- FSM states: IDLE, CMD, LENH, LENL, EXEC, PAY_WAIT, PAY_HI, PAY_LO, CHK, ACK_WAIT, SCK_HI, SCK_LO, FAIL.
- HOST_READY: high in IDLE, CMD, LENH, LENL, PAY_WAIT and CHK; low in all other states.
- IDLE: non-sync bytes are discarded. A sync byte moves to CMD.
- LENL -> EXEC decodes the command:
  - START: set PROGRAMMER_Reset=1, clear DONE/ERR/CODE, set BUSY=1, go to ACK_WAIT. START while already BUSY is legal and restarts the ACK wait.
  - SECTION: requires BUSY and ACK seen, else code 3. Go to SCK_HI.
  - END: requires BUSY, else code 3. Go to CHK.
- ACK_WAIT:
  - Counts cycles; ACK sampled high -> CHK.
  - Counter reaching AckTimeout -> FAIL with code 2.
- SCK_HI / SCK_LO: SCK high for StrobeCycles, then low for StrobeCycles. Then go to PAY_WAIT, or CHK if LEN=0.
- Payload path:
  - PAY_WAIT: on accept, latch byte into InputData and go to PAY_HI.
  - PAY_HI: PCK high for StrobeCycles.
  - PAY_LO: PCK low for StrobeCycles.
  - Decrement the remaining count; at 0 go to CHK, else PAY_WAIT.
  - InputData is stable from one cycle before PCK rises until PCK falls.
- CHK:
  - Mismatch -> FAIL with code 1. Bytes are already streamed; there is no rollback.
  - Match on END: drop PROGRAMMER_Reset, BUSY=0, DONE=1.
  - Return to IDLE.
- FAIL: set ERR and CODE; keep PROGRAMMER_Reset asserted (CPU stays halted); BUSY=0; go to IDLE.
  - Only a START (or nRST) clears the error.
  - A START frame with a bad checksum still leaves Reset asserted and reports code 1.
- ACK dropping during a session is ignored. The CPU unit owns ACK semantics.
- Counters: the strobe counter is sized for StrobeCycles; the ACK counter is 16 bits and saturates. The payload counter is 16 bits with no wrap.
- PCK and SCK are never high simultaneously, and are always separated by >=StrobeCycles low cycles.

Decomposition:
- Shared package prog_loader_pkg: state enum, CMD constants (CMD_START/SECTION/END), error code constants.
- One sub-module, prog_strobe_gen: start pulse in; produces a StrobeCycles-high then StrobeCycles-low pulse; exposes a done flag. It is instantiated once and shared by PCK and SCK via a select.

Test Plan:
- START frame (A5 10 00 00 10), ACK raised after 20 cycles -> Reset=1 within 1 cycle of LENL accept; BUSY=1; ERR=0; FSM returns to IDLE after ACK.
- SECTION with LEN=3, payload 11 22 33, CHK=20^00^03^11^22^33 -> one SCK pulse of 4 cycles, then 3 PCK pulses of 4 cycles each with InputData 11/22/33; HOST_READY low during each strobe.
- END frame (A5 30 00 00 30) -> Reset falls; DONE=1; BUSY=0.
- SECTION frame with wrong CHK -> all payload strobed; ERR=1; CODE=1; Reset stays 1; a following START clears ERR.
- START with ACK held low, AckTimeout=100 -> ERR=1 and CODE=2 after 100 cycles.
- SECTION before START, or CMD=8'h55 -> CODE=3; no PCK/SCK activity. Separately, nRST asserted mid-payload -> all outputs 0 immediately.
